// File: rtl/size_patch_scheduler_pkg.sv
// Shared definitions for the size-field back-patch scheduler: FSM encoding,
// patch width limit and the byte-size normalisation rules.
package size_patch_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int         MAX_PATCH_BYTES = 4;
    localparam logic [2:0] SIZE_NOOP       = 3'd0;
    localparam logic [2:0] SIZE_CLAMP      = 3'(MAX_PATCH_BYTES);

    // Oversized fields are clamped to the widest patch the port can produce.
    function automatic logic [2:0] normalise_size(input logic [2:0] raw);
        return (raw > SIZE_CLAMP) ? SIZE_CLAMP : raw;
    endfunction

    function automatic logic size_is_err(input logic [2:0] raw);
        return raw > SIZE_CLAMP;
    endfunction

    // True when the value has significant bits above the low n bytes.
    function automatic logic value_overflows(input logic [31:0] v, input logic [2:0] n);
        case (n)
            3'd0:    return v != 32'd0;
            3'd1:    return v[31:8] != 24'd0;
            3'd2:    return v[31:16] != 16'd0;
            3'd3:    return v[31:24] != 8'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/size_patch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches from the requester after
// last_grant and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last_grant,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        idx       = 0;
        for (int step = 1; step <= N; step++) begin
            idx = (int'(last_grant) + step) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/size_patch_scheduler.sv
// Shares the back-patch byte write port between size-field producers and
// serialises each value big-endian. Optional PATCH_OVERFLOW_CHECK_EN adds ovf_err.
module size_patch_scheduler
    import size_patch_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_offset,
    input  logic [NUM_REQ*32-1:0]     req_val,
    input  logic [NUM_REQ*3-1:0]      req_byte_size,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data,
    input  logic                      wr_ready,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                grant_id,
    output logic                      err_size
`ifdef PATCH_OVERFLOW_CHECK_EN
    ,
    output logic                      ovf_err
`endif
);

    state_e              state;
    state_e              state_next;
    logic [2:0]          last_grant;
    logic [2:0]          grant_id_q;
    logic [ADDR_W-1:0]   offset_q;
    logic [31:0]         val_q;
    logic [2:0]          n_q;
    logic [2:0]          k_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [2:0]          arb_idx;
    logic                accept;
    logic [ADDR_W-1:0]   sel_offset;
    logic [31:0]         sel_val;
    logic [2:0]          sel_size_raw;
    logic [2:0]          sel_n;
    logic                last_byte;
    logic [1:0]          byte_sel;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Handshake: a transfer happens on any cycle where req_valid[i] and
    // req_ready[i] are both high; ready is only offered to the arbiter winner
    // while IDLE, and the requester holds valid plus payload until then.
    assign req_ready = (state == IDLE) ? arb_grant : '0;
    assign accept    = |(req_valid & req_ready);

    assign sel_offset   = req_offset[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_val      = req_val[int'(arb_idx)*32 +: 32];
    assign sel_size_raw = req_byte_size[int'(arb_idx)*3 +: 3];
    assign sel_n        = normalise_size(sel_size_raw);

    assign last_byte = (k_q == n_q - 3'd1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (sel_n == SIZE_NOOP) ? FINISH : WRITE;
                end
            end
            WRITE: begin
                if (wr_ready && last_byte) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 3'(NUM_REQ - 1);
            grant_id_q <= 3'd0;
            offset_q   <= '0;
            val_q      <= 32'd0;
            n_q        <= 3'd0;
            k_q        <= 3'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= arb_idx;
                grant_id_q <= arb_idx;
                offset_q   <= sel_offset;
                val_q      <= sel_val;
                n_q        <= sel_n;
                k_q        <= 3'd0;
            end else if (state == WRITE && wr_ready) begin
                k_q <= k_q + 3'd1;
            end
        end
    end

    // Byte k carries the (n-1-k)th byte of the value, most significant first.
    assign byte_sel = 2'(n_q - 3'd1 - k_q);

    assign wr_en    = (state == WRITE);
    assign wr_addr  = wr_en ? (offset_q + ADDR_W'(k_q)) : '0;
    assign wr_data  = wr_en ? val_q[int'(byte_sel)*8 +: 8] : 8'd0;
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);
    assign grant_id = grant_id_q;
    assign err_size = accept && size_is_err(sel_size_raw);

`ifdef PATCH_OVERFLOW_CHECK_EN
    assign ovf_err  = accept && value_overflows(sel_val, sel_n);
`endif

endmodule

// File: tb/tb_size_patch_scheduler.sv
// Randomised and directed bench for size_patch_scheduler with a round-robin
// reference model feeding a scoreboard checked by an independent monitor.
module tb_size_patch_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_offset;
    logic [NUM_REQ*32-1:0]     req_val;
    logic [NUM_REQ*3-1:0]      req_byte_size;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [7:0]                wr_data;
    logic                      wr_ready;
    logic                      busy;
    logic                      done;
    logic [2:0]                grant_id;
    logic                      err_size;
`ifdef PATCH_OVERFLOW_CHECK_EN
    logic                      ovf_err;
`endif

    size_patch_scheduler #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_offset   (req_offset),
        .req_val      (req_val),
        .req_byte_size(req_byte_size),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .done         (done),
        .grant_id     (grant_id),
        .err_size     (err_size)
`ifdef PATCH_OVERFLOW_CHECK_EN
        ,
        .ovf_err      (ovf_err)
`endif
    );

    always #5 clock = ~clock;

    // Scoreboard state: expected byte writes {addr, data}; per-request
    // entries {ovf, err, n[2:0], gid[2:0]} for accept and done checks.
    logic [ADDR_W+7:0] exp_q[$];
    logic [7:0]        acc_q[$];
    logic [7:0]        done_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int acc_cyc      = 0;
    int bytes_seen   = 0;
    int stalls       = 0;
    int last_latency = -1;

    logic [2:0]        model_last;
    logic [ADDR_W-1:0] b_off  [NUM_REQ];
    logic [31:0]       b_val  [NUM_REQ];
    logic [2:0]        b_size [NUM_REQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pending requesters are served in cyclic order after the
    // previous grant; each emits min(size,4) bytes, most significant first.
    task automatic model_batch(input logic [NUM_REQ-1:0] mask);
        int                idx;
        int                last_idx;
        int                n;
        logic              ovf;
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        last_idx = int'(model_last);
        for (int step = 1; step <= NUM_REQ; step++) begin
            idx = (int'(model_last) + step) % NUM_REQ;
            if (mask[idx]) begin
                n = (b_size[idx] > 3'd4) ? 4 : int'(b_size[idx]);
                for (int k = 0; k < n; k++) begin
                    a = b_off[idx] + ADDR_W'(k);
                    d = 8'((b_val[idx] >> (8 * (n - 1 - k))) & 32'hFF);
                    exp_q.push_back({a, d});
                end
                ovf = (n < 4) && ((64'(b_val[idx]) >> (8 * n)) != 64'd0);
                acc_q.push_back({ovf, b_size[idx] > 3'd4, 3'(n), 3'(idx)});
                done_q.push_back({ovf, b_size[idx] > 3'd4, 3'(n), 3'(idx)});
                last_idx = idx;
            end
        end
        model_last = 3'(last_idx);
    endtask

    task automatic flush_model();
        exp_q.delete();
        acc_q.delete();
        done_q.delete();
    endtask

    task automatic load_payload();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_offset[i*ADDR_W +: ADDR_W] = b_off[i];
            req_val[i*32 +: 32]            = b_val[i];
            req_byte_size[i*3 +: 3]        = b_size[i];
        end
    endtask

    // bp_mode: 0 = wr_ready high, 1 = random stalls, 2 = three stalls on first byte.
    task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int bp_mode);
        logic [NUM_REQ-1:0] pend;
        logic [NUM_REQ-1:0] acc;
        int                 budget;
        int                 kk;
        bit                 seen;
        model_batch(mask);
        load_payload();
        pend      = mask;
        seen      = 1'b0;
        kk        = 0;
        budget    = 0;
        wr_ready  = (bp_mode != 2);
        req_valid = mask;
        while ((pend != '0 || done_q.size() != 0) && budget < 500) begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock);
            #1;
            req_valid = req_valid & ~acc;
            pend      = pend & ~acc;
            if (seen) kk++;
            if (acc != '0 && !seen) begin
                seen = 1'b1;
                kk   = 0;
            end
            case (bp_mode)
                1:       wr_ready = ($urandom_range(0, 3) != 0);
                2:       wr_ready = seen && (kk >= 3);
                default: wr_ready = 1'b1;
            endcase
            budget++;
        end
        if (budget >= 500) begin
            check("batch_timeout", 64'd1, 64'd0);
            req_valid = '0;
            flush_model();
        end
        wr_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_wr_en"},     64'(wr_en),     64'd0);
        check({tag, "_wr_addr"},   64'(wr_addr),   64'd0);
        check({tag, "_wr_data"},   64'(wr_data),   64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_grant_id"},  64'(grant_id),  64'd0);
        check({tag, "_err_size"},  64'(err_size),  64'd0);
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard.
    always @(negedge clock) begin
        logic [NUM_REQ-1:0] acc;
        logic [7:0]         e;
        int                 gi;
        cyc++;
        if (!reset) begin
            acc = req_valid & req_ready;
            if (acc != '0) begin
                gi = 0;
                for (int i = 0; i < NUM_REQ; i++) if (acc[i]) gi = i;
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 64'd1, 64'd0);
                end else begin
                    e = acc_q.pop_front();
                    check("accept_id", 64'(gi), 64'(e[2:0]));
                    check("err_size", 64'(err_size), 64'(e[6]));
`ifdef PATCH_OVERFLOW_CHECK_EN
                    check("ovf_err", 64'(ovf_err), 64'(e[7]));
`endif
                end
                acc_cyc    = cyc;
                bytes_seen = 0;
                stalls     = 0;
            end else begin
                check("err_size_idle", 64'(err_size), 64'd0);
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("write_addr_data", 64'({wr_addr, wr_data}), 64'(exp_q[0]));
                    if (wr_ready) begin
                        void'(exp_q.pop_front());
                        bytes_seen++;
                    end else begin
                        stalls++;
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = done_q.pop_front();
                    last_latency = cyc - acc_cyc;
                    check("done_grant_id", 64'(grant_id), 64'(e[2:0]));
                    check("done_bytes", 64'(bytes_seen), 64'(e[5:3]));
                    check("done_latency", 64'(last_latency), 64'(int'(e[5:3]) + 1 + stalls));
                    check("finish_no_ready", 64'(req_ready), 64'd0);
                    check("finish_busy", 64'(busy), 64'd1);
                end
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        flush_model();
        model_last = 3'(NUM_REQ - 1);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1;
    endtask

    task automatic clear_payload();
        for (int i = 0; i < NUM_REQ; i++) begin
            b_off[i]  = '0;
            b_val[i]  = 32'd0;
            b_size[i] = 3'd0;
        end
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_offset    = '0;
        req_val       = '0;
        req_byte_size = '0;
        wr_ready      = 1'b0;
        clear_payload();
        do_reset();

        // Single two-byte request.
        b_off[0] = 32'h10; b_val[0] = 32'h1234; b_size[0] = 3'd2;
        run_batch(4'b0001, 0);
        check("single_latency", 64'(last_latency), 64'd3);

        // Simultaneous picture-size and component requests from reset.
        do_reset();
        clear_payload();
        b_off[1] = 32'h81;  b_val[1] = 32'h0000_0ABC; b_size[1] = 3'd4;
        b_off[3] = 32'h202; b_val[3] = 32'h55;        b_size[3] = 3'd2;
        run_batch(4'b1010, 0);

        // Back-pressure on the first byte.
        b_off[2] = 32'h300; b_val[2] = 32'hC0DE; b_size[2] = 3'd2;
        run_batch(4'b0100, 2);
        check("bp_latency", 64'(last_latency), 64'd6);

        // Size edge cases and address wrap.
        b_off[0] = 32'h44; b_val[0] = 32'h99; b_size[0] = 3'd0;
        run_batch(4'b0001, 0);
        check("noop_latency", 64'(last_latency), 64'd1);
        b_off[1] = 32'h50; b_val[1] = 32'hDEAD_BEEF; b_size[1] = 3'd6;
        run_batch(4'b0010, 0);
        b_off[2] = 32'hFFFF_FFFF; b_val[2] = 32'hA1B2; b_size[2] = 3'd2;
        run_batch(4'b0100, 0);

        // Reset during the second byte of a four-byte write.
        b_off[3] = 32'h400; b_val[3] = 32'h1122_3344; b_size[3] = 3'd4;
        model_batch(4'b1000);
        load_payload();
        wr_ready  = 1'b1;
        req_valid = 4'b1000;
        @(negedge clock);
        check("abort_ready", 64'(req_ready), 64'b1000);
        @(posedge clock); #1;
        req_valid = '0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_all_zero("abort");
        @(posedge clock); #1;
        reset = 1'b0;
        flush_model();
        model_last = 3'(NUM_REQ - 1);
        @(negedge clock);
        check_all_zero("abort_idle");
        @(posedge clock); #1;
        b_off[0] = 32'h500; b_val[0] = 32'h77;   b_size[0] = 3'd1;
        b_off[2] = 32'h600; b_val[2] = 32'h8899; b_size[2] = 3'd2;
        run_batch(4'b0101, 0);

        // Randomised batches with random back-pressure.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                b_off[i]  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : 32'($urandom);
                b_val[i]  = 32'($urandom) >> (8 * $urandom_range(0, 3));
                b_size[i] = 3'($urandom_range(0, 7));
            end
            run_batch(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), int'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("acc_q_drained", 64'(acc_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
